// File: rtl/mini_cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the 8-bit mini CPU.
// Optional single-step support: define MINI_CPU_SINGLE_STEP_EN.
module mini_cpu_sequencer #(
    parameter int PC_W          = 3,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
`ifdef MINI_CPU_SINGLE_STEP_EN
    input  logic            step_mode,
    input  logic            step,
`endif
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic            acc_we,
    output logic [1:0]      alu_op,
    output logic [5:0]      imm,
    output logic            busy,
    output logic            halted,
    output logic            error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_ERROR,
        S_PAUSE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t          state;
    logic [7:0]      tmo_cnt;
    logic            stop_q;
    logic            is_jmp;
    logic [PC_W-1:0] jmp_tgt;
    logic            self_jmp;

    // JMP target keeps only the low PC_W bits of imm (PC_W must not exceed 6)
    assign is_jmp   = (alu_op == 2'b11);
    assign jmp_tgt  = imm[PC_W-1:0];
    assign self_jmp = is_jmp && (jmp_tgt == pc);
    assign mem_addr = pc;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            alu_op  <= '0;
            imm     <= '0;
            mem_req <= 1'b0;
            acc_we  <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            error   <= 1'b0;
            tmo_cnt <= '0;
            stop_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        state   <= S_FETCH;
                        pc      <= '0;
                        tmo_cnt <= '0;
                        stop_q  <= 1'b0;
                        halted  <= 1'b0;
                        error   <= 1'b0;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (stop) stop_q <= 1'b1;
                    if (mem_ack) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                        state   <= S_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (stop) stop_q <= 1'b1;
                    alu_op <= ir[7:6];
                    imm    <= ir[5:0];
                    acc_we <= (ir[7:6] != 2'b11);
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    acc_we <= 1'b0;
                    if (!is_jmp) begin
                        pc <= pc + PC_W'(1);
                    end else if (!self_jmp) begin
                        pc <= jmp_tgt;
                    end
                    if (self_jmp) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_HALT;
                    end else if (stop_q || stop) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
`ifdef MINI_CPU_SINGLE_STEP_EN
                    end else if (step_mode) begin
                        state <= S_PAUSE;
`endif
                    end else begin
                        tmo_cnt <= '0;
                        stop_q  <= 1'b0;
                        mem_req <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
`ifdef MINI_CPU_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (step) begin
                        tmo_cnt <= '0;
                        stop_q  <= 1'b0;
                        mem_req <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
`endif
                default: begin
                    mem_req <= 1'b0;
                    acc_we  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mini_cpu_sequencer.sv
// Scoreboard bench for mini_cpu_sequencer: a program-level reference
// model predicts fetch addresses, ALU strobes, final pc and cycle counts.
module tb_mini_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mem_req;
    logic [2:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [2:0] pc;
    logic [7:0] ir;
    logic       acc_we;
    logic [1:0] alu_op;
    logic [5:0] imm;
    logic       busy;
    logic       halted;
    logic       error;

    mini_cpu_sequencer #(.PC_W(3), .FETCH_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pc        (pc),
        .ir        (ir),
        .acc_we    (acc_we),
        .alu_op    (alu_op),
        .imm       (imm),
        .busy      (busy),
        .halted    (halted),
        .error     (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [8];
    int fetch_q [$];
    int exec_q  [$];

    bit serve_en = 1'b0;
    bit rnd_dly  = 1'b0;
    int fix_dly  = 0;
    int cur_dly  = 0;
    int wcnt     = 0;
    int fetch_n  = 0;
    int kstop    = 0;
    int tot_dly  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({mem_req, mem_addr, pc, ir, acc_we,
                     alu_op, imm, busy, halted, error});
    endfunction

    // Program-level reference: walk the program, record fetch/exec events
    task automatic model(input int limit, output int k,
                         output bit hlt, output int fpc);
        int p;
        int op;
        int im;
        logic [7:0] w;
        p   = 0;
        k   = 0;
        hlt = 1'b0;
        while (k < limit && !hlt) begin
            w = mem[p];
            op = int'(w[7:6]);
            im = int'(w[5:0]);
            fetch_q.push_back(p);
            k++;
            if (op != 3) begin
                exec_q.push_back((op << 16) | (im << 8) | p);
                p = (p + 1) % 8;
            end else if ((im % 8) == p) begin
                hlt = 1'b1;
            end else begin
                p = im % 8;
            end
        end
        fpc = p;
    endtask

    // Instruction memory: ack after cur_dly wait cycles, stop on kstop-th fetch
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        stop      = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && serve_en && mem_req && !mem_ack) begin
                if (wcnt >= cur_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    fetch_n++;
                    tot_dly += cur_dly;
                    if (fetch_n == kstop) stop = 1'b1;
                    wcnt    = 0;
                    cur_dly = rnd_dly ? int'($urandom_range(0, 3)) : fix_dly;
                end else begin
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                stop    = 1'b0;
                if (!mem_req) wcnt = 0;
            end
        end
    end

    // Monitor: pop expectations whenever the DUT presents a fetch or a strobe
    logic       prev_req  = 1'b0;
    logic [2:0] prev_addr = '0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (mem_req && prev_req)
                    check("addr_stable", int'(mem_addr), int'(prev_addr));
                if (mem_req && mem_ack) begin
                    if (fetch_q.size() == 0) begin
                        errors++;
                        $display("FAIL fetch_extra: addr %0d, none expected",
                                 mem_addr);
                    end else begin
                        check("fetch_addr", int'(mem_addr), fetch_q.pop_front());
                    end
                end
                if (acc_we) begin
                    if (exec_q.size() == 0) begin
                        errors++;
                        $display("FAIL exec_extra: op %0d imm %0d, none expected",
                                 alu_op, imm);
                    end else begin
                        check("exec_op_imm_pc",
                              (int'(alu_op) << 16) | (int'(imm) << 8) | int'(pc),
                              exec_q.pop_front());
                    end
                end
            end
            prev_req  = mem_req && !rst;
            prev_addr = mem_addr;
        end
    end

    task automatic run(input int limit, input bit rnd, input int fdly,
                       output int cyc);
        int k;
        bit hlt;
        int fpc;
        int sp;
        model(limit, k, hlt, fpc);
        kstop    = k;
        fetch_n  = 0;
        tot_dly  = 0;
        rnd_dly  = rnd;
        fix_dly  = fdly;
        cur_dly  = rnd ? int'($urandom_range(0, 3)) : fdly;
        wcnt     = 0;
        serve_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        check("start_pc", int'(pc), 0);
        check("start_flags", int'({mem_req, busy, error, halted}), 'b1100);
        sp = int'($urandom_range(1, 2));
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == sp);
        end
        start = 1'b0;
        #3;
        check("run_cycles", cyc, 3 * k + tot_dly);
        check("end_pc", int'(pc), fpc);
        check("end_halted", int'(halted), int'(hlt));
        check("end_busy", int'(busy), 0);
        check("fetch_q_left", fetch_q.size(), 0);
        check("exec_q_left", exec_q.size(), 0);
        fetch_q.delete();
        exec_q.delete();
    endtask

    task automatic load_spec_prog();
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'b00_000011;
        mem[1] = 8'b01_000010;
        mem[2] = 8'b10_000001;
        mem[3] = 8'b11_000011;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        #12;
        check("reset_outputs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0;

        load_spec_prog();
        run(20, 1'b0, 0, cyc);
        check("spec_prog_cycles", cyc, 12);
        run(20, 1'b0, 3, cyc);
        check("slow_ack_cycles", cyc, 24);
        run(2, 1'b0, 0, cyc);
        check("stop_pc_idle", int'(pc), 2);

        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'b11_000101;
        mem[5] = 8'b11_101111;
        mem[7] = 8'b00_000001;
        run(7, 1'b0, 1, cyc);

        serve_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!error && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, 15);
        check("timeout_flags", int'({error, mem_req, busy}), 'b100);

        load_spec_prog();
        run(20, 1'b1, 0, cyc);

        serve_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_req", int'(mem_req), 1);
        #1 rst = 1'b1;
        #1 check("midfetch_reset", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", int'({busy, mem_req, error, halted}), 0);

        for (int r = 0; r < 10; r++) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
            run(20, 1'b1, 0, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
